// File: rtl/simd_alu_addsub_pipe.sv
// simd_alu_addsub_pipe
//   Two-stage pipelined SIMD add/subtract for the ALU datapath. Lanes are
//   8/16/32/64 bits wide, signed or unsigned, with optional saturation and
//   per-lane overflow/underflow flags. Valid/ready on both sides with full
//   backpressure; results appear two cycles after an input transfer.
//
// Ports
//   clk, rst_n        clock, synchronous active-low reset
//   in_valid/in_ready operand handshake (in_ready is combinational from out_ready)
//   a, b              operand vectors
//   data_mode         lane size: 0=8, 1=16, 2=32, 3=64; 4..7 reserved (zero result)
//   data_signed       two's complement lanes
//   op_sub            0 = a+b, 1 = a-b
//   sat_en            clamp lanes on overflow/underflow
//   out_valid/out_ready result handshake
//   result, ovf, udf  lane results and flags; lane k of N bits flags bit k*(N/8)
//   sticky_ovf/udf    OR of all delivered ovf/udf bits since the last clear
//   sticky_clr        clears both sticky flags
module simd_alu_addsub_pipe #(
    parameter int SIMD_DATA_WIDTH            = 256,
    parameter int SIMD_ADDER_DATA_MODE_WIDTH = 3
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [SIMD_DATA_WIDTH-1:0]            a,
    input  logic [SIMD_DATA_WIDTH-1:0]            b,
    input  logic [SIMD_ADDER_DATA_MODE_WIDTH-1:0] data_mode,
    input  logic                                  data_signed,
    input  logic                                  op_sub,
    input  logic                                  sat_en,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [SIMD_DATA_WIDTH-1:0]            result,
    output logic [SIMD_DATA_WIDTH/8-1:0]          ovf,
    output logic [SIMD_DATA_WIDTH/8-1:0]          udf,
    output logic                                  sticky_ovf,
    output logic                                  sticky_udf,
    input  logic                                  sticky_clr
);

    localparam int CHUNKS = SIMD_DATA_WIDTH / 64;
    localparam int FLAG_W = SIMD_DATA_WIDTH / 8;

    // Sign- or zero-extends the low n bits of both lanes to 66 bits and
    // adds/subtracts; 66 bits hold every unsigned 64-bit sum and difference.
    function automatic logic signed [65:0] lane_sum(
        input logic [63:0] x,
        input logic [63:0] y,
        input int          n,
        input logic        sgn,
        input logic        sub
    );
        logic [65:0] m;
        logic [65:0] ex;
        logic [65:0] ey;
        logic [5:0]  msb;
        m   = (66'd1 << n) - 66'd1;
        msb = 6'(n - 1);
        ex  = {2'b00, x} & m;
        ey  = {2'b00, y} & m;
        if (sgn && x[msb]) ex = ex | ~m;
        if (sgn && y[msb]) ey = ey | ~m;
        return sub ? ($signed(ex) - $signed(ey)) : ($signed(ex) + $signed(ey));
    endfunction

    // Range check and clamp of one wide lane result back to n bits.
    function automatic void saturate_lane(
        input  logic signed [65:0] s,
        input  int                 n,
        input  logic               sgn,
        input  logic               sat,
        output logic [63:0]        res,
        output logic               o,
        output logic               u
    );
        logic signed [65:0] hi;
        logic signed [65:0] lo;
        logic        [65:0] m;
        m = (66'd1 << n) - 66'd1;
        if (sgn) begin
            hi = $signed(m >> 1);   // 2^(n-1)-1
            lo = ~hi;               // -2^(n-1)
        end else begin
            hi = $signed(m);
            lo = '0;
        end
        o = (s > hi);
        u = (s < lo);
        if (sat && o)      res = hi[63:0];
        else if (sat && u) res = lo[63:0];
        else               res = s[63:0];
        res = res & m[63:0];
    endfunction

    logic                                  vld_p1;
    logic [SIMD_DATA_WIDTH-1:0]            a_p1;
    logic [SIMD_DATA_WIDTH-1:0]            b_p1;
    logic [SIMD_ADDER_DATA_MODE_WIDTH-1:0] mode_p1;
    logic                                  signed_p1;
    logic                                  sub_p1;
    logic                                  sat_p1;

    logic                                  vld_p2;
    logic [SIMD_DATA_WIDTH-1:0]            result_p2;
    logic [FLAG_W-1:0]                     ovf_p2;
    logic [FLAG_W-1:0]                     udf_p2;

    logic [SIMD_DATA_WIDTH-1:0]            res_nxt;
    logic [FLAG_W-1:0]                     ovf_nxt;
    logic [FLAG_W-1:0]                     udf_nxt;

    logic s2_load;
    logic s1_load;
    logic out_xfer;
    logic mode_ok;

    assign s2_load  = ~vld_p2 | out_ready;
    assign s1_load  = ~vld_p1 | s2_load;
    assign in_ready = s1_load;
    assign out_xfer = vld_p2 & out_ready;
    assign mode_ok  = ((mode_p1 >> 2) == '0);

    assign out_valid = vld_p2;
    assign result    = result_p2;
    assign ovf       = ovf_p2;
    assign udf       = udf_p2;

    // ---- S1: operand and control capture ----
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
        end else if (s1_load) begin
            vld_p1 <= in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (s1_load && in_valid) begin
            a_p1      <= a;
            b_p1      <= b;
            mode_p1   <= data_mode;
            signed_p1 <= data_signed;
            sub_p1    <= op_sub;
            sat_p1    <= sat_en;
        end
    end

    // ---- S1 -> S2: lane arithmetic, processed in 64-bit chunks ----
    always_comb begin
        logic [63:0]        chunk_a;
        logic [63:0]        chunk_b;
        logic [63:0]        chunk_res;
        logic [63:0]        lane_res;
        logic [7:0]         chunk_ovf;
        logic [7:0]         chunk_udf;
        logic signed [65:0] wide;
        logic               lane_o;
        logic               lane_u;
        logic [2:0]         fidx;
        int                 n;
        int                 lanes;

        res_nxt   = '0;
        ovf_nxt   = '0;
        udf_nxt   = '0;
        chunk_a   = '0;
        chunk_b   = '0;
        chunk_res = '0;
        lane_res  = '0;
        chunk_ovf = '0;
        chunk_udf = '0;
        wide      = '0;
        lane_o    = 1'b0;
        lane_u    = 1'b0;
        fidx      = '0;
        n         = 8 << mode_p1[1:0];
        lanes     = 64 / n;

        if (mode_ok) begin
            for (int g = 0; g < CHUNKS; g++) begin
                chunk_a   = a_p1[g*64 +: 64];
                chunk_b   = b_p1[g*64 +: 64];
                chunk_res = '0;
                chunk_ovf = '0;
                chunk_udf = '0;
                for (int j = 0; j < 8; j++) begin
                    if (j < lanes) begin
                        wide = lane_sum(chunk_a >> (j*n), chunk_b >> (j*n), n, signed_p1, sub_p1);
                        saturate_lane(wide, n, signed_p1, sat_p1, lane_res, lane_o, lane_u);
                        chunk_res = chunk_res | (lane_res << (j*n));
                        // flags sit on the lowest byte position the lane covers
                        fidx            = 3'(j * (n / 8));
                        chunk_ovf[fidx] = lane_o;
                        chunk_udf[fidx] = lane_u;
                    end
                end
                res_nxt[g*64 +: 64] = chunk_res;
                ovf_nxt[g*8 +: 8]   = chunk_ovf;
                udf_nxt[g*8 +: 8]   = chunk_udf;
            end
        end
    end

    // ---- S2: result register ----
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p2    <= 1'b0;
            result_p2 <= '0;
            ovf_p2    <= '0;
            udf_p2    <= '0;
        end else if (s2_load) begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                result_p2 <= res_nxt;
                ovf_p2    <= ovf_nxt;
                udf_p2    <= udf_nxt;
            end
        end
    end

    // ---- Sticky flags, updated on delivered beats ----
    // A clear coinciding with a flagged transfer leaves the new flag set.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sticky_ovf <= 1'b0;
            sticky_udf <= 1'b0;
        end else if (sticky_clr) begin
            sticky_ovf <= out_xfer & (|ovf_p2);
            sticky_udf <= out_xfer & (|udf_p2);
        end else if (out_xfer) begin
            sticky_ovf <= sticky_ovf | (|ovf_p2);
            sticky_udf <= sticky_udf | (|udf_p2);
        end
    end

endmodule

// File: tb/tb_simd_alu_addsub_pipe.sv
// Testbench for simd_alu_addsub_pipe: directed vector table, hand-written
// handshake/reset/sticky sequences and a randomized run against a lane model.
module tb_simd_alu_addsub_pipe;

    localparam int W  = 256;
    localparam int FW = W / 8;
    localparam int MW = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [MW-1:0] data_mode;
    logic          data_signed;
    logic          op_sub;
    logic          sat_en;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  result;
    logic [FW-1:0] ovf;
    logic [FW-1:0] udf;
    logic          sticky_ovf;
    logic          sticky_udf;
    logic          sticky_clr;

    always #5 clk = ~clk;

    simd_alu_addsub_pipe #(
        .SIMD_DATA_WIDTH(W),
        .SIMD_ADDER_DATA_MODE_WIDTH(MW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .data_mode(data_mode), .data_signed(data_signed),
        .op_sub(op_sub), .sat_en(sat_en),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .ovf(ovf), .udf(udf),
        .sticky_ovf(sticky_ovf), .sticky_udf(sticky_udf), .sticky_clr(sticky_clr)
    );

    typedef struct {
        string         name;
        logic [W-1:0]  va;
        logic [W-1:0]  vb;
        logic [MW-1:0] mode;
        logic          sgn;
        logic          sub;
        logic          sat;
        logic [W-1:0]  exp_res;
        logic [FW-1:0] exp_ovf;
        logic [FW-1:0] exp_udf;
    } vec_t;

    typedef struct {
        logic [W-1:0]  r;
        logic [FW-1:0] o;
        logic [FW-1:0] u;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string nm, input logic [W-1:0] va, input logic [W-1:0] vb,
                                input logic [MW-1:0] m, input logic s, input logic su, input logic sa,
                                input logic [W-1:0] r, input logic [FW-1:0] o, input logic [FW-1:0] u);
        vec_t v;
        v.name = nm; v.va = va; v.vb = vb; v.mode = m; v.sgn = s; v.sub = su; v.sat = sa;
        v.exp_res = r; v.exp_ovf = o; v.exp_udf = u;
        return v;
    endfunction

    // Lane model: each lane is turned into a mathematical integer, combined,
    // range-checked against the lane's representable interval, then clamped
    // or reduced modulo 2^N.
    function automatic void model(input logic [W-1:0] va, input logic [W-1:0] vb, input logic [MW-1:0] m,
                                  input logic s, input logic su, input logic sa,
                                  output logic [W-1:0] r, output logic [FW-1:0] o, output logic [FW-1:0] u);
        int                 n;
        logic signed [127:0] full, half, x, y, v, lo, hi;
        logic        [127:0] ua, ub, lane;
        r = '0; o = '0; u = '0;
        if (m > 3) return;
        n    = 8 << m;
        full = 128'sd1 <<< n;
        half = full >>> 1;
        hi   = s ? (half - 128'sd1) : (full - 128'sd1);
        lo   = s ? -half : 128'sd0;
        for (int k = 0; k < W / n; k++) begin
            ua = 128'(va >> (k*n)) & 128'(full - 128'sd1);
            ub = 128'(vb >> (k*n)) & 128'(full - 128'sd1);
            x  = $signed(ua);
            y  = $signed(ub);
            if (s && x >= half) x = x - full;
            if (s && y >= half) y = y - full;
            v = su ? (x - y) : (x + y);
            if (v > hi) begin
                o[k*n/8] = 1'b1;
                if (sa) v = hi;
            end else if (v < lo) begin
                u[k*n/8] = 1'b1;
                if (sa) v = lo;
            end
            lane = 128'(v) & 128'(full - 128'sd1);
            r = r | (W'(lane) << (k*n));
        end
    endfunction

    function automatic logic [W-1:0] rand_vec();
        logic [W-1:0] v;
        logic [7:0]   byt;
        v = '0;
        for (int i = 0; i < W / 8; i++) begin
            case ($urandom_range(0, 7))
                0:       byt = 8'h00;
                1:       byt = 8'hFF;
                2:       byt = 8'h7F;
                3:       byt = 8'h80;
                default: byt = 8'($urandom);
            endcase
            v[i*8 +: 8] = byt;
        end
        return v;
    endfunction

    task automatic drive(input logic [W-1:0] va, input logic [W-1:0] vb, input logic [MW-1:0] m,
                         input logic s, input logic su, input logic sa);
        a = va; b = vb; data_mode = m; data_signed = s; op_sub = su; sat_en = sa;
    endtask

    // Sends one beat into an empty pipeline and checks the 2-cycle latency and
    // the delivered values; optionally raises sticky_clr on the output transfer.
    task automatic run_vec(input vec_t v, input bit clr);
        drive(v.va, v.vb, v.mode, v.sgn, v.sub, v.sat);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        check({v.name, " in_ready"}, W'(in_ready), W'(1'b1));
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check({v.name, " out_valid@1"}, W'(out_valid), W'(1'b0));
        @(posedge clk); #1;
        @(negedge clk);
        check({v.name, " out_valid@2"}, W'(out_valid), W'(1'b1));
        check({v.name, " result"}, result, v.exp_res);
        check({v.name, " ovf"}, W'(ovf), W'(v.exp_ovf));
        check({v.name, " udf"}, W'(udf), W'(v.exp_udf));
        sticky_clr = clr;
        @(posedge clk); #1;
        sticky_clr = 1'b0;
    endtask

    task automatic chk_sticky(input string nm, input logic eo, input logic eu);
        @(negedge clk);
        check({nm, " sticky_ovf"}, W'(sticky_ovf), W'(eo));
        check({nm, " sticky_udf"}, W'(sticky_udf), W'(eu));
        @(posedge clk); #1;
    endtask

    task automatic clr_alone(input string nm);
        sticky_clr = 1'b1;
        @(posedge clk); #1;
        sticky_clr = 1'b0;
        chk_sticky(nm, 1'b0, 1'b0);
    endtask

    initial begin
        exp_t         e;
        logic [W-1:0] held;
        bit           stalled;
        bit           m_o, m_u, fo, fu;
        int           seen;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; sticky_clr = 1'b0;
        drive('0, '0, '0, 1'b0, 1'b0, 1'b0);

        tbl.push_back(mk("u8 add wrap", W'(8'hFF), W'(8'h01), 3'd0, 0, 0, 0, W'(8'h00), FW'(1), FW'(0)));
        tbl.push_back(mk("u8 add sat", W'(8'hFF), W'(8'h01), 3'd0, 0, 0, 1, W'(8'hFF), FW'(1), FW'(0)));
        tbl.push_back(mk("s8 sub sat", W'(8'h80), W'(8'h01), 3'd0, 1, 1, 1, W'(8'h80), FW'(0), FW'(1)));
        tbl.push_back(mk("s8 sub wrap", W'(8'h80), W'(8'h01), 3'd0, 1, 1, 0, W'(8'h7F), FW'(0), FW'(1)));
        tbl.push_back(mk("s64 add sat", W'(64'h7FFF_FFFF_FFFF_FFFF), W'(64'd1), 3'd3, 1, 0, 1,
                         W'(64'h7FFF_FFFF_FFFF_FFFF), FW'(1), FW'(0)));
        tbl.push_back(mk("u64 sub wrap", {64'd5, 128'd0, 64'd0}, {64'd3, 128'd0, 64'd1}, 3'd3, 0, 1, 0,
                         {64'd2, 128'd0, 64'hFFFF_FFFF_FFFF_FFFF}, FW'(0), FW'(1)));
        tbl.push_back(mk("s16 add lane1", {224'd0, 16'h7FFF, 16'd0}, {224'd0, 16'h0001, 16'd0}, 3'd1, 1, 0, 0,
                         {224'd0, 16'h8000, 16'd0}, FW'(32'h4), FW'(0)));
        tbl.push_back(mk("u32 add lane1 sat", {192'd0, 32'hFFFF_FFFF, 32'd0}, {192'd0, 32'd2, 32'd0}, 3'd2, 0, 0, 1,
                         {192'd0, 32'hFFFF_FFFF, 32'd0}, FW'(32'h10), FW'(0)));
        tbl.push_back(mk("reserved mode5", W'(8'hFF), W'(8'h01), 3'd5, 0, 0, 0, '0, FW'(0), FW'(0)));
        tbl.push_back(mk("u8 add clean", W'(8'h12), W'(8'h34), 3'd0, 0, 0, 0, W'(8'h46), FW'(0), FW'(0)));
        tbl.push_back(mk("u16 sub sat", {16'hFFFF, 224'd0, 16'h0001}, {16'h0001, 224'd0, 16'h0002}, 3'd1, 0, 1, 1,
                         {16'hFFFE, 240'd0}, FW'(0), FW'(1)));
        tbl.push_back(mk("s8 add top udf", {8'h80, 248'd0}, {8'h80, 248'd0}, 3'd0, 1, 0, 1,
                         {8'h80, 248'd0}, FW'(0), FW'(32'h8000_0000)));
        tbl.push_back(mk("reserved mode7", '1, '1, 3'd7, 1, 1, 1, '0, FW'(0), FW'(0)));

        // reset state
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst out_valid", W'(out_valid), W'(1'b0));
        check("rst in_ready", W'(in_ready), W'(1'b1));
        check("rst result", result, '0);
        check("rst ovf", W'(ovf), '0);
        check("rst udf", W'(udf), '0);
        check("rst sticky_ovf", W'(sticky_ovf), W'(1'b0));
        check("rst sticky_udf", W'(sticky_udf), W'(1'b0));
        @(posedge clk); #1;

        foreach (tbl[i]) run_vec(tbl[i], 1'b0);

        // sticky flags
        clr_alone("clr0");
        run_vec(tbl[0], 1'b0);
        chk_sticky("after ovf beat", 1'b1, 1'b0);
        run_vec(tbl[9], 1'b0);
        chk_sticky("after clean beat", 1'b1, 1'b0);
        run_vec(tbl[2], 1'b0);
        chk_sticky("after udf beat", 1'b1, 1'b1);
        run_vec(tbl[0], 1'b1);
        chk_sticky("clr with ovf xfer", 1'b1, 1'b0);
        clr_alone("clr alone");

        // backpressure: three beats offered with out_ready low
        out_ready = 1'b0;
        drive(W'(8'h01), W'(8'h10), 3'd0, 0, 0, 0);
        in_valid = 1'b1;
        @(negedge clk);
        check("bp accept0", W'(in_ready), W'(1'b1));
        @(posedge clk); #1;
        drive(W'(8'h02), W'(8'h10), 3'd0, 0, 0, 0);
        @(negedge clk);
        check("bp accept1", W'(in_ready), W'(1'b1));
        @(posedge clk); #1;
        drive(W'(8'h03), W'(8'h10), 3'd0, 0, 0, 0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("bp in_ready low", W'(in_ready), W'(1'b0));
            check("bp out_valid", W'(out_valid), W'(1'b1));
            check("bp held result", result, W'(8'h11));
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp accept2", W'(in_ready), W'(1'b1));
        for (int k = 0; k < 3; k++) begin
            if (k > 0) @(negedge clk);
            check("bp drain valid", W'(out_valid), W'(1'b1));
            check("bp drain order", result, W'(8'h11 + k));
            @(posedge clk); #1;
            in_valid = 1'b0;
        end
        @(negedge clk);
        check("bp drained", W'(out_valid), W'(1'b0));
        @(posedge clk); #1;

        // reset with two flagged beats in flight
        drive(W'(8'hFF), W'(8'h01), 3'd0, 0, 0, 0);
        in_valid = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst_n    = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst out_valid", W'(out_valid), W'(1'b0));
        check("midrst in_ready", W'(in_ready), W'(1'b1));
        check("midrst sticky_ovf", W'(sticky_ovf), W'(1'b0));
        check("midrst sticky_udf", W'(sticky_udf), W'(1'b0));
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("midrst no stale beat", W'(seen), W'(0));
        @(posedge clk); #1;

        // randomized run against the lane model
        m_o = 1'b0; m_u = 1'b0; stalled = 1'b0; held = '0;
        for (int c = 0; c < 620; c++) begin
            @(negedge clk);
            check("rnd sticky_ovf", W'(sticky_ovf), W'(m_o));
            check("rnd sticky_udf", W'(sticky_udf), W'(m_u));
            if (stalled) check("rnd stall hold", result, held);
            fo = 1'b0; fu = 1'b0;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL rnd unexpected beat: got %h want none", result);
                end else begin
                    e = sb.pop_front();
                    check("rnd result", result, e.r);
                    check("rnd ovf", W'(ovf), W'(e.o));
                    check("rnd udf", W'(udf), W'(e.u));
                    fo = |e.o; fu = |e.u;
                end
            end
            if (sticky_clr) begin
                m_o = fo; m_u = fu;
            end else begin
                m_o = m_o | fo; m_u = m_u | fu;
            end
            stalled = out_valid && !out_ready;
            held    = result;
            if (in_valid && in_ready) begin
                model(a, b, data_mode, data_signed, op_sub, sat_en, e.r, e.o, e.u);
                sb.push_back(e);
            end
            @(posedge clk); #1;
            if (c < 600) begin
                in_valid   = ($urandom_range(0, 3) != 0);
                out_ready  = ($urandom_range(0, 3) != 0);
                sticky_clr = ($urandom_range(0, 15) == 0);
                drive(rand_vec(), rand_vec(),
                      ($urandom_range(0, 7) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3)),
                      1'($urandom), 1'($urandom), 1'($urandom));
            end else begin
                in_valid   = 1'b0;
                out_ready  = 1'b1;
                sticky_clr = 1'b0;
            end
        end
        check("rnd all beats delivered", W'(sb.size()), W'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
